reg_pair_tx: RTL and testbench
==============================

# reg_pair_tx

Serial transmitter for the x/y register pair. It accepts a 3-bit `x` and an 8-bit `y` field through a valid/ready handshake, holds them in registers that reset to literal defaults, and shifts them out one bit per clock as an 11-bit frame. It drives the serial link whose receiving end rebuilds the x/y pair, and it also exposes the held values to local logic.

## Interface

Parameters:
- `X_WIDTH`, default 3: width of the x field.
- `Y_WIDTH`, default 8: width of the y field.
- `X_INIT`, default 5: reset value of the x holding register. Zero-extended or truncated to `X_WIDTH`.
- `Y_INIT`, default 5: reset value of the y holding register. Zero-extended or truncated to `Y_WIDTH`.

Ports:
- `clk`  in  1: the only clock; all state changes on its rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `x_in`  in  `X_WIDTH`: x field to send.
- `y_in`  in  `Y_WIDTH`: y field to send.
- `in_valid`  in  1: the `x_in`/`y_in` pair is offered.
- `in_ready`  out  1: the block can accept a pair this cycle.
- `ser_out`  out  1: serial data bit.
- `ser_valid`  out  1: `ser_out` carries a frame bit this cycle.
- `done`  out  1: one-cycle pulse coinciding with the last frame bit.
- `x_out`  out  `X_WIDTH`: x holding register.
- `y_out`  out  `Y_WIDTH`: y holding register.

## Operation

- Frame length is N = `X_WIDTH` + `Y_WIDTH` (11 by default).
- Bit order on the wire: x[0] up to x[X_WIDTH-1], then y[0] up to y[Y_WIDTH-1]. The frame is sent LSB first and has no start or stop bits.
- State machine has two states:
  - IDLE: `in_ready`=1, `ser_valid`=0, `ser_out`=0.
  - SHIFT: `in_ready`=0, `ser_valid`=1.
- Transition IDLE → SHIFT: when `in_valid` && `in_ready`.
  - On that edge, load `x_out`/`y_out` from `x_in`/`y_in`.
  - On the same edge, load the shift register with {y_in, x_in}.
  - On the same edge, clear the bit counter to 0.
- In SHIFT:
  - `ser_out` = shift register bit 0.
  - Each cycle the shift register moves right by 1 and zero-fills the MSB.
  - Each cycle the counter increments by 1.
- Transition SHIFT → IDLE: on the cycle where counter = N-1. `done`=1 in that cycle only.
- The counter is clog2(N) bits wide and never exceeds N-1, so it never wraps.
- `in_valid` is ignored in SHIFT. The input is not latched, and `x_out`/`y_out` keep the accepted pair.
- `x_out`/`y_out` change only on an accept or a reset. They keep their value after the frame ends.
- Reset values while `rst` is high and on the cycle after:
  - State IDLE, `in_ready`=1.
  - `ser_valid`=0, `ser_out`=0, `done`=0.
  - `x_out`=`X_INIT`, `y_out`=`Y_INIT`.
  - Counter 0, shift register 0.
- `rst` dominates every other input.

## Timing

- An accept at edge T puts frame bit 0 on `ser_out` in cycle T+1 and bit k in cycle T+1+k.
- The last bit and `done` appear in cycle T+N (T+11 by default).
- `in_ready` returns to 1 in cycle T+N+1.
- The earliest next accept is at edge T+N+1, so back-to-back frames are separated by exactly one idle cycle with `ser_valid`=0.
- `in_ready` depends only on state, never combinationally on `in_valid`.
- All outputs are registered or decoded from registered state.
- Reset mid-frame: on the edge where `rst`=1 the frame is abandoned.
  - `ser_valid` is 0 in the following cycle.
  - No `done` pulse is issued for the aborted frame.
  - `x_out`/`y_out` return to their init values.
- If `rst` and `in_valid` are both high, the reset wins and the pair is not accepted.

## Structure

- Shared package `reg_pair_pkg`:
  - State enum: IDLE, SHIFT.
  - Default constants: `X_WIDTH_D`=3, `Y_WIDTH_D`=8, `X_INIT_D`=5, `Y_INIT_D`=5.
  - Frame-length function.
- The receiving end of the link uses the same package.
- One sub-module, `piso_shreg`: a parallel-in serial-out shift register with load, shift-enable and synchronous reset, parameterised by width.
- The FSM, counter and holding registers stay in `reg_pair_tx`.

## Test plan

- Reset: hold `rst` for 2 cycles → `x_out`=3'h5, `y_out`=8'h5, `in_ready`=1, `ser_valid`=0, `done`=0.
- Single frame with x=3'b110, y=8'hA5, accepted at edge T:
  - `ser_out` over cycles T+1..T+11 is 0,1,1,1,0,1,0,0,1,0,1.
  - `done` is high only in cycle T+11.
  - `x_out`=6 and `y_out`=A5 from T+1 onward.
- Busy ignore: `in_valid` held high with x=1, y=8'hFF throughout the frame from the single-frame case →
  - The first frame is unchanged.
  - The second accept happens at T+12.
  - The second frame's bits start at T+13.
- Reset mid-frame: assert `rst` in cycle T+5 →
  - `ser_valid`=0 from T+6.
  - No `done` pulse.
  - `x_out`=5, `y_out`=5.
  - The next accept is a clean full frame.
- Simultaneous `rst` and `in_valid` with x=7, y=8'h00 → no accept, `x_out`=5, `y_out`=5, no frame.
- Idle hold: `in_valid`=0 for 50 cycles after a frame → `ser_valid`=0, `x_out`/`y_out` unchanged.

Source files
------------

// File: rtl/reg_pair_pkg.sv
// Shared definitions for both ends of the x/y register-pair serial link:
// FSM states, default field widths/reset values, and the frame length.
package reg_pair_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int X_WIDTH_D = 3;
    localparam int Y_WIDTH_D = 8;
    localparam int X_INIT_D  = 5;
    localparam int Y_INIT_D  = 5;

    function automatic int frame_len(input int x_width, input int y_width);
        return x_width + y_width;
    endfunction

endpackage

// File: rtl/reg_pair_tx_piso_shreg.sv
// Parallel-in serial-out shift register: load wins over shift, shifts
// right by one with a zero fill in the MSB, LSB presented on dout.
module piso_shreg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             load,
    input  logic             shift_en,
    input  logic [WIDTH-1:0] din,
    output logic             dout
);

    logic [WIDTH-1:0] sh_reg;
    logic [WIDTH-1:0] sh_next;

    generate
        for (genvar gi = 0; gi < WIDTH - 1; gi++) begin : g_shift
            assign sh_next[gi] = sh_reg[gi+1];
        end
    endgenerate
    assign sh_next[WIDTH-1] = 1'b0;

    always_ff @(posedge clk) begin
        if (srst) begin
            sh_reg <= '0;
        end else if (load) begin
            sh_reg <= din;
        end else if (shift_en) begin
            sh_reg <= sh_next;
        end
    end

    assign dout = sh_reg[0];

endmodule

// File: rtl/reg_pair_tx.sv
// Serial transmitter for the x/y register pair: accepts a pair on a
// valid/ready handshake, holds it, and sends {y, x} LSB first.
module reg_pair_tx
    import reg_pair_pkg::*;
#(
    parameter int X_WIDTH = X_WIDTH_D,
    parameter int Y_WIDTH = Y_WIDTH_D,
    parameter int X_INIT  = X_INIT_D,
    parameter int Y_INIT  = Y_INIT_D
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [X_WIDTH-1:0] x_in,
    input  logic [Y_WIDTH-1:0] y_in,
    input  logic               in_valid,
    output logic               in_ready,
    output logic               ser_out,
    output logic               ser_valid,
    output logic               done,
    output logic [X_WIDTH-1:0] x_out,
    output logic [Y_WIDTH-1:0] y_out
);

    localparam int N     = frame_len(X_WIDTH, Y_WIDTH);
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [X_WIDTH-1:0] x_reg;
    logic [Y_WIDTH-1:0] y_reg;
    logic               accept;
    logic               last_bit;
    logic               shreg_bit;

    assign accept   = (state_reg == IDLE) && in_valid;
    assign last_bit = (state_reg == SHIFT) && (cnt_reg == CNT_W'(N - 1));

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    state_next = SHIFT;
                    cnt_next   = '0;
                end
            end
            SHIFT: begin
                // Parking the counter at 0 keeps it within 0..N-1.
                if (last_bit) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            x_reg     <= X_WIDTH'(X_INIT);
            y_reg     <= Y_WIDTH'(Y_INIT);
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (accept) begin
                x_reg <= x_in;
                y_reg <= y_in;
            end
        end
    end

    piso_shreg #(
        .WIDTH(N)
    ) u_shreg (
        .clk     (clk),
        .srst    (rst),
        .load    (accept),
        .shift_en(state_reg == SHIFT),
        .din     ({y_in, x_in}),
        .dout    (shreg_bit)
    );

    assign in_ready  = (state_reg == IDLE);
    assign ser_valid = (state_reg == SHIFT);
    assign ser_out   = (state_reg == SHIFT) && shreg_bit;
    assign done      = last_bit;
    assign x_out     = x_reg;
    assign y_out     = y_reg;

endmodule

// File: tb/tb_reg_pair_tx.sv
// Self-checking bench for reg_pair_tx: directed scenarios plus random
// traffic, all compared against a frame-position reference model.
module tb_reg_pair_tx;

    localparam int XW = 3;
    localparam int YW = 8;
    localparam int N  = XW + YW;

    logic          clk = 1'b0;
    logic          rst;
    logic [XW-1:0] x_in;
    logic [YW-1:0] y_in;
    logic          in_valid;
    logic          in_ready;
    logic          ser_out;
    logic          ser_valid;
    logic          done;
    logic [XW-1:0] x_out;
    logic [YW-1:0] y_out;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    reg_pair_tx dut (
        .clk      (clk),
        .rst      (rst),
        .x_in     (x_in),
        .y_in     (y_in),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .ser_out  (ser_out),
        .ser_valid(ser_valid),
        .done     (done),
        .x_out    (x_out),
        .y_out    (y_out)
    );

    // Reference model: m_pos is 0 when idle, otherwise k means frame bit k-1
    // is on the wire; the expected bit is taken arithmetically from {y, x}.
    int            m_pos = 0;
    logic [XW-1:0] m_x   = 3'd5;
    logic [YW-1:0] m_y   = 8'd5;

    always @(posedge clk) begin
        if (rst) begin
            m_pos = 0;
            m_x   = 3'd5;
            m_y   = 8'd5;
        end else if (m_pos == 0) begin
            if (in_valid) begin
                m_pos = 1;
                m_x   = x_in;
                m_y   = y_in;
            end
        end else begin
            m_pos = (m_pos == N) ? 0 : m_pos + 1;
        end
    end

    function automatic logic [14:0] model_vec();
        int   frame;
        logic b;
        frame = (int'(m_y) << XW) + int'(m_x);
        b = (m_pos != 0) ? logic'((frame >> (m_pos - 1)) & 1) : 1'b0;
        return {m_pos == 0, m_pos != 0, b, m_pos == N, m_x, m_y};
    endfunction

    wire [14:0] obs_vec = {in_ready, ser_valid, ser_out, done, x_out, y_out};

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; x_in = '0; y_in = '0;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            vectors++;
            if ({in_ready, ser_valid, ser_out, done, x_out, y_out} !== {4'b1000, 3'h5, 8'h05}) begin
                miscompares++;
                $display("FAIL reset c=%0d got rdy=%b sv=%b so=%b dn=%b x=%h y=%h want rdy=1 sv=0 so=0 dn=0 x=5 y=05",
                         c, in_ready, ser_valid, ser_out, done, x_out, y_out);
            end
        end
        rst = 1'b0;
        @(posedge clk); #1;
        vectors++;
        if (obs_vec !== model_vec()) begin
            miscompares++;
            $display("FAIL reset_release got %h want %h", obs_vec, model_vec());
        end
    endtask

    task automatic test_single_frame();
        logic [N-1:0] got;
        logic [N-1:0] want;
        int           done_cnt;
        int           done_at;
        want = 11'b10100101110;
        got = '0; done_cnt = 0; done_at = -1;
        x_in = 3'b110; y_in = 8'hA5; in_valid = 1'b1;
        for (int k = 1; k <= N + 1; k++) begin
            @(posedge clk); #1;
            in_valid = 1'b0;
            vectors++;
            if (obs_vec !== model_vec()) begin
                miscompares++;
                $display("FAIL single k=%0d got %h want %h", k, obs_vec, model_vec());
            end
            if (k <= N) got[k-1] = ser_out;
            if (done) begin done_cnt++; done_at = k; end
        end
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL single_bits got %b want %b", got, want);
        end
        vectors++;
        if (done_cnt != 1 || done_at != N) begin
            miscompares++;
            $display("FAIL single_done got count=%0d at=%0d want count=1 at=%0d", done_cnt, done_at, N);
        end
    endtask

    task automatic test_back_to_back();
        int second_start;
        second_start = -1;
        x_in = 3'b110; y_in = 8'hA5; in_valid = 1'b1;
        for (int k = 1; k <= N + 3; k++) begin
            @(posedge clk); #1;
            x_in = 3'd1; y_in = 8'hFF;
            vectors++;
            if (obs_vec !== model_vec()) begin
                miscompares++;
                $display("FAIL busy k=%0d got %h want %h", k, obs_vec, model_vec());
            end
            if (k > N && ser_valid && second_start < 0) second_start = k;
        end
        in_valid = 1'b0;
        vectors++;
        if (second_start != N + 2) begin
            miscompares++;
            $display("FAIL busy_second_start got %0d want %0d", second_start, N + 2);
        end
        for (int k = 0; k < N; k++) begin
            @(posedge clk); #1;
            vectors++;
            if (obs_vec !== model_vec()) begin
                miscompares++;
                $display("FAIL busy_drain k=%0d got %h want %h", k, obs_vec, model_vec());
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        int done_cnt;
        done_cnt = 0;
        x_in = 3'd2; y_in = 8'h3C; in_valid = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); #1;
            in_valid = 1'b0;
            rst = (k == 4);
            vectors++;
            if (obs_vec !== model_vec()) begin
                miscompares++;
                $display("FAIL rst_mid k=%0d got %h want %h", k, obs_vec, model_vec());
            end
            if (done) done_cnt++;
            if (k == 5) begin
                vectors++;
                if ({ser_valid, x_out, y_out} !== {1'b0, 3'h5, 8'h05}) begin
                    miscompares++;
                    $display("FAIL rst_mid_abort got sv=%b x=%h y=%h want sv=0 x=5 y=05", ser_valid, x_out, y_out);
                end
            end
        end
        vectors++;
        if (done_cnt != 0) begin
            miscompares++;
            $display("FAIL rst_mid_done got %0d pulses want 0", done_cnt);
        end
        x_in = 3'd4; y_in = 8'h81; in_valid = 1'b1;
        for (int k = 1; k <= N + 1; k++) begin
            @(posedge clk); #1;
            in_valid = 1'b0;
            vectors++;
            if (obs_vec !== model_vec()) begin
                miscompares++;
                $display("FAIL rst_mid_clean k=%0d got %h want %h", k, obs_vec, model_vec());
            end
        end
    endtask

    task automatic test_reset_and_valid();
        x_in = 3'd7; y_in = 8'h00; in_valid = 1'b1; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            vectors++;
            if ({ser_valid, in_ready, x_out, y_out} !== {2'b01, 3'h5, 8'h05}) begin
                miscompares++;
                $display("FAIL rst_valid k=%0d got sv=%b rdy=%b x=%h y=%h want sv=0 rdy=1 x=5 y=05",
                         k, ser_valid, in_ready, x_out, y_out);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_idle_hold();
        logic [XW-1:0] hx;
        logic [YW-1:0] hy;
        hx = 3'($urandom); hy = 8'($urandom);
        x_in = hx; y_in = hy; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (N) @(posedge clk);
        #1;
        for (int k = 0; k < 50; k++) begin
            x_in = 3'($urandom); y_in = 8'($urandom);
            @(posedge clk); #1;
            vectors++;
            if ({ser_valid, done, x_out, y_out} !== {2'b00, hx, hy}) begin
                miscompares++;
                $display("FAIL idle_hold k=%0d got sv=%b dn=%b x=%h y=%h want sv=0 dn=0 x=%h y=%h",
                         k, ser_valid, done, x_out, y_out, hx, hy);
            end
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 600; k++) begin
            x_in     = 3'($urandom);
            y_in     = 8'($urandom);
            in_valid = ($urandom_range(0, 2) == 0);
            rst      = ($urandom_range(0, 59) == 0);
            @(posedge clk); #1;
            vectors++;
            if (obs_vec !== model_vec()) begin
                miscompares++;
                $display("FAIL random k=%0d got %h want %h", k, obs_vec, model_vec());
            end
        end
        rst = 1'b0; in_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; x_in = '0; y_in = '0;
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_reset_mid_frame();
        test_reset_and_valid();
        test_idle_hold();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
